seq_det_cfg: RTL

SEQ_DET_CFG -- requirements
Module: seq_det_cfg

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/sat_counter.sv | 36 +++
 rtl/seq_det_cfg.sv | 97 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared FSM state encodings and the power-on pattern helper for the
// configurable serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Alternating 1,0,1,... starting at bit w-1; callers slice to their width.
    function automatic logic [15:0] default_pat(input int w);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w && ((w - 1 - i) % 2 == 0)) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_cfg.sv
// Serial pattern detector with a loadable pattern, selectable overlapping
// detection and a saturating match counter.
module seq_det_cfg
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seq_in,
    input  logic             in_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_data,
    input  logic             cnt_clr,
    output logic             detected,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state_out
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W - 1);
    localparam logic [PAT_W-1:0] PAT_RST  = PAT_W'(default_pat(PAT_W));

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             det_q, det_d;
    logic             match;
    logic [PAT_W-1:0] window;

    // Candidate window: stored history followed by the bit arriving now.
    assign window = {hist_q, seq_in};

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        det_d   = 1'b0;
        match   = 1'b0;
        if (pat_load) begin
            pat_d   = pat_data;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_LOAD;
        end else if (state_q == ST_LOAD) begin
            state_d = ST_FILL;
        end else if (in_valid) begin
            match  = (fill_q == FILL_MAX) && (window == pat_q);
            det_d  = match;
            hist_d = window[PAT_W-2:0];
            if (match && !overlap_en) begin
                // Non-overlapping: the next match needs a full set of fresh bits.
                fill_d  = '0;
                state_d = ST_FILL;
            end else begin
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FW'(1);
                end
                state_d = (fill_d == FILL_MAX) ? ST_ARMED : ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (match),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );

    assign detected  = det_q;
    assign state_out = state_q;

endmodule
